sram_arb_ctrl: RTL and testbench
================================

SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- ACC_CYCLES, 2, cycles We_n/Oe_n held low per access (legal range 1..15).
- DEPTH, 8, number of implemented SRAM words; legal addresses are 0..DEPTH-1.
REQ-002 The block SHALL expose these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Req  in  2  per-requester request, held high until the matching Ack.
- Wr  in  2  per-requester op: 1=write, 0=read; stable while Req is high.
- Addr  in  8  packed 4-bit word address; [3:0]=req0, [7:4]=req1.
- Wdata  in  32  packed 16-bit write data; [15:0]=req0, [31:16]=req1.
- Ack  out  2  one-cycle completion pulse per requester.
- Rdata  out  16  read data; valid only in the Ack cycle of a read.
- Err  out  1  high with Ack when the address is >= DEPTH.
- Busy  out  1  high whenever the FSM is not IDLE.
- Cs_n, We_n, Oe_n  out  1 each  active-low SRAM strobes, all registered.
- Sram_addr  out  4  SRAM address, registered.
- Sram_dout  out  16  write data toward the SRAM.
- Sram_doe  out  1  tri-state enable for Sram_dout (the wrapper drives IO).
- Sram_din  in  16  IO value read back from the SRAM.

Function
REQ-003 The FSM SHALL have the states IDLE, SETUP, ACCESS, RECOVER and ERR.
REQ-004 IDLE SHALL arbitrate among the high Req bits.
- If none is high, the FSM stays in IDLE.
- Out-of-range address: go to ERR.
- Otherwise: latch the winner id, Wr, Addr and Wdata, then go to SETUP.
REQ-005 SETUP SHALL last 1 cycle.
- Cs_n=0, We_n=1, Oe_n=1, Sram_addr valid.
- For writes, Sram_doe=1 and Sram_dout valid, so the data is stable before We_n falls.
REQ-006 ACCESS SHALL last exactly ACC_CYCLES cycles, counted by a down-counter.
- Write: We_n=0.
- Read: Oe_n=0, with Sram_din captured on the last ACCESS cycle.
REQ-007 RECOVER SHALL last 1 cycle, then return to IDLE.
- Cs_n=0, We_n=1, Oe_n=1.
- Write data still driven.
- Ack[id]=1; Rdata=captured word for a read, 0 for a write.
REQ-008 ERR SHALL last 1 cycle, then return to IDLE.
- Ack[id]=1, Err=1, Rdata=0.
- All strobes stay high; the SRAM is not touched.
REQ-009 Latency from the IDLE cycle that samples Req to the Ack cycle SHALL be ACC_CYCLES+2 cycles (4 at the default). ERR SHALL take 1 cycle.
REQ-010 We_n and Oe_n SHALL never be low in the same cycle. Sram_doe SHALL be 0 whenever Oe_n=0.
REQ-011 The requester SHALL drop Req at the edge where it samples Ack. Req sampled high in IDLE is treated as a new request.
REQ-012 Requests arriving outside IDLE SHALL wait; no request is dropped or reordered within a requester.

Reset
REQ-013 rst SHALL force the following at the next edge, with priority over all other logic:
- FSM to IDLE.
- Cs_n=We_n=Oe_n=1.
- Sram_addr=0, Sram_dout=0, Sram_doe=0.
- Ack=0, Rdata=0, Err=0, Busy=0.
- Arbitration pointer set so that requester 0 wins first.
REQ-014 Reset during SETUP, ACCESS or RECOVER SHALL abandon the access with no Ack.
- A write whose We_n had fallen may leave that word indeterminate.

Configuration
REQ-015 With SRAM_ARB_RR_EN defined, arbitration SHALL be round-robin.
- On simultaneous requests, the requester not granted last wins.
- The pointer updates on every grant, including ERR.
REQ-016 Without SRAM_ARB_RR_EN, arbitration SHALL be fixed priority with requester 0 highest; the pointer logic SHALL be absent.

Structure
REQ-017 The shared package sram_pkg SHALL hold the following:
- FSM state encodings.
- DATA_W=16 and ADDR_W=4.
- The requester count NREQ=2.
REQ-018 Arbitration SHALL be a sub-module, rr_arbiter2 (req[1:0] -> one-hot gnt, with the pointer), instantiated by sram_arb_ctrl.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single write, then read-back: req0 writes 0xA5C3 to addr 3, then reads addr 3 -> Ack0 at 4 cycles each, Rdata=0xA5C3, Err=0, We_n low for exactly 2 cycles.
- Simultaneous requests with SRAM_ARB_RR_EN: Req=2'b11 held over 4 accesses -> grants alternate 0,1,0,1.
- Simultaneous requests without the macro: the same stimulus -> req0 is served every time req0 is high; req1 is served only when Req0=0.
- Out-of-range address: req1 reads addr 9 -> Ack1 and Err high 1 cycle after sampling, Cs_n never low, Rdata=0.
- Reset mid-write: rst asserted during ACCESS -> all strobes high at the next edge, no Ack, Busy=0; a following read of another address returns its prior value.
- Strobe protocol checker: across all tests -> Oe_n and We_n never both 0; Sram_doe=0 whenever Oe_n=0; Sram_addr stable while Cs_n=0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and sizes for the two-requester SRAM arbiter/controller.
package sram_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREQ   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StRecover,
    StErr
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter producing a one-hot grant. Round-robin when SRAM_ARB_RR_EN is
// defined, otherwise fixed priority with requester 0 highest and no pointer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

`ifdef SRAM_ARB_RR_EN
  // Id of the requester granted most recently; reset to 1 so requester 0 wins first.
  logic r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_adv) begin
      r_last <= o_gnt[1];
    end
  end

  always_comb begin
    o_gnt = i_req;
    if (&i_req) begin
      o_gnt = r_last ? 2'b01 : 2'b10;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, rst, i_adv};

  always_comb begin
    o_gnt = i_req[0] ? 2'b01 : i_req;
  end
`endif

endmodule

// File: rtl/sram_arb_ctrl.sv
// Arbitrates two requesters onto one asynchronous SRAM with registered strobes.
// Define SRAM_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
module sram_arb_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ACC_CYCLES = 2,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        Req,
  input  logic [NREQ-1:0]        Wr,
  input  logic [NREQ*ADDR_W-1:0] Addr,
  input  logic [NREQ*DATA_W-1:0] Wdata,
  output logic [NREQ-1:0]        Ack,
  output logic [DATA_W-1:0]      Rdata,
  output logic                   Err,
  output logic                   Busy,
  output logic                   Cs_n,
  output logic                   We_n,
  output logic                   Oe_n,
  output logic [ADDR_W-1:0]      Sram_addr,
  output logic [DATA_W-1:0]      Sram_dout,
  output logic                   Sram_doe,
  input  logic [DATA_W-1:0]      Sram_din
);

  state_e              r_state, w_state_d;
  logic [3:0]          r_cnt, w_cnt_d;
  logic                r_id, r_wr, w_id_d, w_wr_d;
  logic                r_cs_n, r_we_n, r_oe_n, r_doe, r_err;
  logic                w_cs_n_d, w_we_n_d, w_oe_n_d, w_doe_d, w_err_d;
  logic [NREQ-1:0]     r_ack, w_ack_d, w_gnt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_d, r_sram_dout;
  logic [ADDR_W-1:0]   r_sram_addr, w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_grant, w_win_id, w_adv, w_oor;

  assign w_grant     = |w_gnt;
  assign w_win_id    = w_gnt[1];
  assign w_adv       = (r_state == StIdle) && w_grant;
  assign w_sel_addr  = w_win_id ? Addr[2*ADDR_W-1:ADDR_W] : Addr[ADDR_W-1:0];
  assign w_sel_wdata = w_win_id ? Wdata[2*DATA_W-1:DATA_W] : Wdata[DATA_W-1:0];
  assign w_oor       = 32'(w_sel_addr) >= DEPTH;
  // In IDLE the transaction fields come straight from the winner, later from the latch.
  assign w_id_d      = (r_state == StIdle) ? w_win_id : r_id;
  assign w_wr_d      = (r_state == StIdle) ? Wr[w_win_id] : r_wr;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (Req),
    .i_adv (w_adv),
    .o_gnt (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_id        <= 1'b0;
      r_wr        <= 1'b0;
      r_cs_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_doe       <= 1'b0;
      r_err       <= 1'b0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_sram_dout <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_id    <= w_id_d;
      r_wr    <= w_wr_d;
      r_cs_n  <= w_cs_n_d;
      r_we_n  <= w_we_n_d;
      r_oe_n  <= w_oe_n_d;
      r_doe   <= w_doe_d;
      r_err   <= w_err_d;
      r_ack   <= w_ack_d;
      r_rdata <= w_rdata_d;
      if (w_adv && !w_oor) begin
        r_sram_addr <= w_sel_addr;
        r_sram_dout <= w_sel_wdata;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_grant) w_state_d = w_oor ? StErr : StSetup;
      end
      StSetup: begin
        w_state_d = StAccess;
        w_cnt_d   = 4'(ACC_CYCLES - 1);
      end
      StAccess: begin
        if (r_cnt == '0) w_state_d = StRecover;
        else             w_cnt_d   = r_cnt - 4'd1;
      end
      StRecover, StErr: w_state_d = StIdle;
      default:          w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    w_cs_n_d  = !(w_state_d inside {StSetup, StAccess, StRecover});
    w_we_n_d  = !((w_state_d == StAccess) && w_wr_d);
    w_oe_n_d  = !((w_state_d == StAccess) && !w_wr_d);
    w_doe_d   = w_wr_d && (w_state_d inside {StSetup, StAccess, StRecover});
    w_err_d   = (w_state_d == StErr);
    w_ack_d   = '0;
    w_rdata_d = '0;
    if (w_state_d inside {StRecover, StErr}) w_ack_d[w_id_d] = 1'b1;
    // Entering RECOVER is the edge closing the last ACCESS cycle: capture there.
    if ((w_state_d == StRecover) && !w_wr_d) w_rdata_d = Sram_din;
  end

  assign Ack       = r_ack;
  assign Rdata     = r_rdata;
  assign Err       = r_err;
  assign Busy      = (r_state != StIdle);
  assign Cs_n      = r_cs_n;
  assign We_n      = r_we_n;
  assign Oe_n      = r_oe_n;
  assign Sram_addr = r_sram_addr;
  assign Sram_dout = r_sram_dout;
  assign Sram_doe  = r_doe;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Self-checking bench for sram_arb_ctrl: transaction-phase model, SRAM model,
// per-cycle compare and protocol checks, plus directed literal expectations.
module tb_sram_arb_ctrl;

  localparam int ACC  = 2;
  localparam int DEP  = 8;
  localparam int LAST = ACC + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_v  [2];
  logic        wr_v   [2];
  logic [3:0]  addr_v [2];
  logic [15:0] wd_v   [2];

  logic [1:0]  Req, Wr, Ack;
  logic [7:0]  Addr;
  logic [31:0] Wdata;
  logic [15:0] Rdata, Sram_dout, Sram_din;
  logic [3:0]  Sram_addr;
  logic        Err, Busy, Cs_n, We_n, Oe_n, Sram_doe;

  assign Req   = {req_v[1], req_v[0]};
  assign Wr    = {wr_v[1], wr_v[0]};
  assign Addr  = {addr_v[1], addr_v[0]};
  assign Wdata = {wd_v[1], wd_v[0]};

  sram_arb_ctrl #(.ACC_CYCLES(ACC), .DEPTH(DEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .Req       (Req),
    .Wr        (Wr),
    .Addr      (Addr),
    .Wdata     (Wdata),
    .Ack       (Ack),
    .Rdata     (Rdata),
    .Err       (Err),
    .Busy      (Busy),
    .Cs_n      (Cs_n),
    .We_n      (We_n),
    .Oe_n      (Oe_n),
    .Sram_addr (Sram_addr),
    .Sram_dout (Sram_dout),
    .Sram_doe  (Sram_doe),
    .Sram_din  (Sram_din)
  );

  // Asynchronous SRAM device model
  logic [15:0] sram [16];
  assign Sram_din = (!Cs_n && !Oe_n) ? sram[Sram_addr] : 16'hDEAD;
  always @(posedge clk) if (!Cs_n && !We_n && Sram_doe) sram[Sram_addr] <= Sram_dout;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: m_p counts cycles since the grant (0 = idle).
  int          cyc = 0;
  bit          started = 0;
  int          m_p = 0;
  logic        m_err = 1'b0, m_wr = 1'b0, m_id = 1'b0, m_last = 1'b1;
  logic [3:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic [15:0] m_mem [8];
  logic        m_valid [8];

  always @(posedge clk) begin
    cyc++;
    started = 1;
    if (rst) begin
      if (m_p >= 2 && !m_err && m_wr) m_valid[m_addr[2:0]] = 1'b0;
      m_p    = 0;
      m_last = 1'b1;
    end else if (m_p == 0) begin
      if (req_v[0] || req_v[1]) begin
        if (req_v[0] && req_v[1]) begin
`ifdef SRAM_ARB_RR_EN
          m_id = ~m_last;
`else
          m_id = 1'b0;
`endif
        end else begin
          m_id = req_v[1];
        end
        m_last = m_id;
        m_wr   = wr_v[m_id];
        m_addr = addr_v[m_id];
        m_data = wd_v[m_id];
        m_err  = (int'(m_addr) >= DEP);
        m_p    = 1;
      end
    end else if (m_err || m_p == LAST) begin
      if (!m_err && m_wr) begin
        m_mem[m_addr[2:0]]   = m_data;
        m_valid[m_addr[2:0]] = 1'b1;
      end
      m_p = 0;
    end else begin
      m_p++;
    end
  end

  // Per-cycle compare and strobe protocol checks
  int   ack_total = 0, we_low_cnt = 0, cs_low_cnt = 0;
  int   ack_order[$];
  logic prev_cs_low = 1'b0;
  logic [3:0] prev_addr = '0;
  logic act, nrm, e_cs_n, e_we_n, e_oe_n, e_doe;
  logic [1:0] e_ack;

  always @(negedge clk) begin
    if (started) begin
      act    = (m_p != 0);
      nrm    = act && !m_err;
      e_cs_n = !nrm;
      e_we_n = !(nrm && m_wr && m_p >= 2 && m_p <= ACC + 1);
      e_oe_n = !(nrm && !m_wr && m_p >= 2 && m_p <= ACC + 1);
      e_doe  = nrm && m_wr;
      e_ack  = 2'b00;
      if (act && (m_err || m_p == LAST)) e_ack[m_id] = 1'b1;
      chk("busy", 32'(Busy), 32'(act));
      chk("cs_n", 32'(Cs_n), 32'(e_cs_n));
      chk("we_n", 32'(We_n), 32'(e_we_n));
      chk("oe_n", 32'(Oe_n), 32'(e_oe_n));
      chk("doe", 32'(Sram_doe), 32'(e_doe));
      chk("ack", 32'(Ack), 32'(e_ack));
      chk("err", 32'(Err), 32'(act && m_err));
      if (e_ack != 2'b00) begin
        if (m_err || m_wr) chk("rdata_zero", 32'(Rdata), 32'h0);
        else if (m_valid[m_addr[2:0]]) chk("rdata", 32'(Rdata), 32'(m_mem[m_addr[2:0]]));
      end
      if (!e_cs_n) chk("sram_addr", 32'(Sram_addr), 32'(m_addr));
      if (e_doe) chk("sram_dout", 32'(Sram_dout), 32'(m_data));
      chk("we_oe_excl", 32'(!(!We_n && !Oe_n)), 32'h1);
      chk("doe_when_oe", 32'(!(!Oe_n && Sram_doe)), 32'h1);
      if (prev_cs_low && !Cs_n) chk("addr_stable", 32'(Sram_addr), 32'(prev_addr));
      prev_cs_low = !Cs_n;
      prev_addr   = Sram_addr;
      if (!We_n) we_low_cnt++;
      if (!Cs_n) cs_low_cnt++;
      if (Ack != 2'b00) ack_total++;
      if (Ack == 2'b01) ack_order.push_back(0);
      if (Ack == 2'b10) ack_order.push_back(1);
    end
  end

  task automatic do_single(input int k, input logic wr, input logic [3:0] addr,
                           input logic [15:0] data, output int lat,
                           output logic [15:0] rd, output logic er);
    int   t0;
    logic got;
    @(posedge clk); #1;
    req_v[k] = 1'b1; wr_v[k] = wr; addr_v[k] = addr; wd_v[k] = data;
    t0 = cyc; got = 1'b0; lat = -1; rd = 'x; er = 'x;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (Ack[k]) begin
        got = 1'b1; lat = cyc - t0; rd = Rdata; er = Err;
      end
    end
    chk("ack_arrived", 32'(got), 32'h1);
    @(posedge clk); #1;
    req_v[k] = 1'b0;
  endtask

  // Back-to-back requester: write then read the same word, Req held between jobs.
  task automatic requester(input int k, input logic [3:0] addr);
    logic got;
    for (int j = 0; j < 2; j++) begin
      req_v[k] = 1'b1; wr_v[k] = (j == 0); addr_v[k] = addr; wd_v[k] = 16'hC0DE ^ 16'(k);
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (Ack[k]) got = 1'b1;
      end
      chk("rq_ack_arrived", 32'(got), 32'h1);
      @(posedge clk); #1;
    end
    req_v[k] = 1'b0;
  endtask

  int          lat;
  logic [15:0] rd;
  logic        er;
  int          ack_before;
  logic        seen;

  initial begin
    for (int i = 0; i < 16; i++) sram[i] = 16'(i * 16'h1111);
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = 16'(i * 16'h1111); m_valid[i] = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 1'b0; wr_v[k] = 1'b0; addr_v[k] = '0; wd_v[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(Busy), 32'h0);
    chk("reset_strobes", 32'({Cs_n, We_n, Oe_n}), 32'h7);
    chk("reset_ack_rdata", 32'({Ack, Rdata}), 32'h0);
    chk("reset_addr_doe", 32'({Sram_addr, Sram_doe}), 32'h0);

    // Write 0xA5C3 to addr 3, then read it back
    we_low_cnt = 0;
    do_single(0, 1'b1, 4'd3, 16'hA5C3, lat, rd, er);
    chk("wr_latency", 32'(lat), 32'd4);
    chk("wr_we_low_cycles", 32'(we_low_cnt), 32'd2);
    chk("wr_err", 32'(er), 32'h0);
    do_single(0, 1'b0, 4'd3, 16'h0, lat, rd, er);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_data", 32'(rd), 32'hA5C3);
    chk("rd_err", 32'(er), 32'h0);

    // Boundary addresses: DEPTH-1 is legal, DEPTH is not
    do_single(1, 1'b1, 4'd7, 16'h7E57, lat, rd, er);
    do_single(0, 1'b0, 4'd7, 16'h0, lat, rd, er);
    chk("rd_addr7", 32'(rd), 32'h7E57);
    do_single(0, 1'b0, 4'd0, 16'h0, lat, rd, er);
    chk("rd_addr0", 32'(rd), 32'h0);
    do_single(0, 1'b1, 4'd8, 16'hFFFF, lat, rd, er);
    chk("err_addr8", 32'({lat[3:0], er}), 32'({4'd1, 1'b1}));

    // Out-of-range read by requester 1
    cs_low_cnt = 0;
    do_single(1, 1'b0, 4'd9, 16'h0, lat, rd, er);
    chk("oor_latency", 32'(lat), 32'd1);
    chk("oor_err", 32'(er), 32'h1);
    chk("oor_rdata", 32'(rd), 32'h0);
    chk("oor_cs_never_low", 32'(cs_low_cnt), 32'd0);

    // Reset during the ACCESS phase of a write to addr 5
    @(posedge clk); #1;
    req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 4'd5; wd_v[0] = 16'hBEEF;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (!We_n) seen = 1'b1;
    end
    chk("mid_we_fell", 32'(seen), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; req_v[0] = 1'b0;
    ack_before = ack_total;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_strobes", 32'({Cs_n, We_n, Oe_n}), 32'h7);
    chk("mid_rst_busy_ack", 32'({Busy, Ack}), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    chk("mid_rst_no_ack", 32'(ack_total), 32'(ack_before));
    do_single(0, 1'b0, 4'd2, 16'h0, lat, rd, er);
    chk("after_rst_rd2", 32'(rd), 32'h2222);

    // Simultaneous requests held over four accesses, from a fresh pointer
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ack_order.delete();
    fork
      requester(0, 4'd6);
      requester(1, 4'd1);
    join
    chk("arb_count", 32'(ack_order.size()), 32'd4);
    if (ack_order.size() == 4) begin
`ifdef SRAM_ARB_RR_EN
      chk("arb_order", 32'({ack_order[0][0], ack_order[1][0], ack_order[2][0],
                            ack_order[3][0]}), 32'b0101);
`else
      chk("arb_order", 32'({ack_order[0][0], ack_order[1][0], ack_order[2][0],
                            ack_order[3][0]}), 32'b0011);
`endif
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
